// File: rtl/fx_bus_ctrl.sv
// Transaction sequencer for the shared 8-bit fx register bus.
// Runs one host access at a time through select, strobe, read-latency wait and ack.
module fx_bus_ctrl #(
    parameter int unsigned RD_LAT   = 2,
    parameter logic [7:0]  ERR_DATA = 8'hEE
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_err,
    output logic        busy,
    output logic [7:0]  fx_cs,
    output logic [7:0]  fx_a,
    output logic [7:0]  fx_d,
    output logic        fx_wr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q
);

    localparam int unsigned DW    = 8;
    localparam int unsigned NSLV  = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic              wr_q, wr_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [NSLV-1:0]   cs_nxt;
    logic [DW-1:0]     a_nxt, d_nxt, rdata_nxt;
    logic              wr_stb_nxt, rd_stb_nxt, ack_nxt, err_nxt, busy_nxt;

    // Outputs are computed for the state being entered so they register in step with it
    always_comb begin
        state_nxt  = state;
        wr_nxt     = wr_q;
        cnt_nxt    = cnt_q;
        cs_nxt     = '0;
        a_nxt      = fx_a;
        d_nxt      = fx_d;
        rdata_nxt  = host_rdata;
        wr_stb_nxt = 1'b0;
        rd_stb_nxt = 1'b0;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (host_req) begin
                    wr_nxt = host_wr;
                    if (host_addr[15:11] == '0) begin
                        state_nxt = S_SETUP;
                        cs_nxt    = NSLV'(1) << host_addr[10:8];
                        a_nxt     = host_addr[7:0];
                        d_nxt     = host_wdata;
                    end else begin
                        state_nxt = S_ERR;
                        ack_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        rdata_nxt = ERR_DATA;
                    end
                end
            end
            S_SETUP: begin
                state_nxt  = S_STROBE;
                cs_nxt     = fx_cs;
                wr_stb_nxt = wr_q;
                rd_stb_nxt = !wr_q;
            end
            S_STROBE: begin
                if (wr_q) begin
                    state_nxt = S_DONE;
                    ack_nxt   = 1'b1;
                    a_nxt     = '0;
                    d_nxt     = '0;
                end else begin
                    state_nxt = S_WAIT;
                    cs_nxt    = fx_cs;
                    cnt_nxt   = CNT_W'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                // Capture edge: the slave has had RD_LAT cycles to drive fx_q
                if (cnt_q == '0) begin
                    state_nxt = S_DONE;
                    ack_nxt   = 1'b1;
                    a_nxt     = '0;
                    d_nxt     = '0;
                    rdata_nxt = fx_q;
                end else begin
                    cs_nxt  = fx_cs;
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            host_err   <= 1'b0;
            busy       <= 1'b0;
            fx_cs      <= '0;
            fx_a       <= '0;
            fx_d       <= '0;
            fx_wr      <= 1'b0;
            fx_rd      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_q       <= wr_nxt;
            cnt_q      <= cnt_nxt;
            host_ack   <= ack_nxt;
            host_rdata <= rdata_nxt;
            host_err   <= err_nxt;
            busy       <= busy_nxt;
            fx_cs      <= cs_nxt;
            fx_a       <= a_nxt;
            fx_d       <= d_nxt;
            fx_wr      <= wr_stb_nxt;
            fx_rd      <= rd_stb_nxt;
        end
    end

endmodule

// File: tb/tb_fx_bus_ctrl.sv
// Self-checking bench for fx_bus_ctrl: directed vector table, multi-cycle corner
// sequences and random accesses scored against a register-file model.
module tb_fx_bus_ctrl;

    localparam int RD_LAT = 2;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        host_req, host_wr;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack, host_err, busy, fx_wr, fx_rd;
    logic [7:0]  host_rdata, fx_cs, fx_a, fx_d, fx_q;

    logic        l1_req, l1_wr;
    logic [15:0] l1_addr;
    logic [7:0]  l1_wdata;
    logic        l1_ack, l1_err, l1_busy, l1_fx_wr, l1_fx_rd;
    logic [7:0]  l1_rdata, l1_fx_cs, l1_fx_a, l1_fx_d, l1_fx_q;

    always #5 clk_sys = ~clk_sys;

    fx_bus_ctrl #(.RD_LAT(RD_LAT), .ERR_DATA(8'hEE)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err), .busy(busy),
        .fx_cs(fx_cs), .fx_a(fx_a), .fx_d(fx_d), .fx_wr(fx_wr), .fx_rd(fx_rd), .fx_q(fx_q)
    );

    fx_bus_ctrl #(.RD_LAT(1), .ERR_DATA(8'hEE)) dut1 (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .host_req(l1_req), .host_wr(l1_wr), .host_addr(l1_addr), .host_wdata(l1_wdata),
        .host_ack(l1_ack), .host_rdata(l1_rdata), .host_err(l1_err), .busy(l1_busy),
        .fx_cs(l1_fx_cs), .fx_a(l1_fx_a), .fx_d(l1_fx_d), .fx_wr(l1_fx_wr), .fx_rd(l1_fx_rd),
        .fx_q(l1_fx_q)
    );

    // Slave register files behind the bus, OR-combined onto fx_q
    logic       mem_clr;
    logic [7:0] smem [8][256];

    always @(posedge clk_sys) begin
        if (mem_clr) begin
            for (int s = 0; s < 8; s++)
                for (int r = 0; r < 256; r++) smem[s][r] <= 8'h00;
        end else if (fx_wr) begin
            for (int s = 0; s < 8; s++)
                if (fx_cs[s]) smem[s][fx_a] <= fx_d;
        end
    end

    always_comb begin
        fx_q = 8'h00;
        for (int s = 0; s < 8; s++)
            if (fx_cs[s]) fx_q = fx_q | smem[s][fx_a];
    end

    assign l1_fx_q = l1_fx_cs[3] ? 8'h7E : 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain register file plus last returned data
    logic [7:0] ref_mem [8][256];
    logic [7:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic model(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         output logic [7:0] e_cs, output int e_lat, output logic e_err,
                         output logic [7:0] e_rdata);
        int base;
        int off;
        base = int'(addr[15:8]);
        off  = int'(addr[7:0]);
        if (base > 7) begin
            e_cs = 8'h00; e_lat = 1; e_err = 1'b1; e_rdata = 8'hEE;
        end else begin
            e_cs  = 8'(1 << base);
            e_err = 1'b0;
            if (wr) begin
                ref_mem[base][off] = wd;
                e_lat   = 3;
                e_rdata = last_rdata;
            end else begin
                e_lat   = 3 + RD_LAT;
                e_rdata = ref_mem[base][off];
            end
        end
        last_rdata = e_rdata;
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] e_cs, input int e_lat,
                           input logic e_err, input logic [7:0] e_rdata);
        int cyc, nwr, nrd, both, bad, wr_at, rd_at;
        logic [7:0] a1, d1;
        logic valid;
        valid = !e_err;
        nwr = 0; nrd = 0; both = 0; bad = 0; wr_at = 0; rd_at = 0;
        host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wd;
        step;
        cyc = 1;
        a1 = fx_a; d1 = fx_d;
        host_req = 1'b0;
        host_addr = 16'($urandom);
        host_wr = 1'($urandom);
        host_wdata = 8'($urandom);
        while (1) begin
            if (fx_wr) begin nwr++; wr_at = cyc; end
            if (fx_rd) begin nrd++; rd_at = cyc; end
            if (fx_wr && fx_rd) both++;
            if (!host_ack) begin
                if (fx_cs !== e_cs || !busy) bad++;
            end else if (fx_cs !== 8'h00) bad++;
            if (host_ack || cyc >= 40) break;
            step;
            cyc++;
        end
        check({tag, " ack latency"}, 32'(cyc), 32'(e_lat));
        check({tag, " host_err"}, 32'(host_err), 32'(e_err));
        check({tag, " host_rdata"}, 32'(host_rdata), 32'(e_rdata));
        check({tag, " fx_cs/busy bad cycles"}, 32'(bad), 32'd0);
        check({tag, " fx_wr count"}, 32'(nwr), 32'(valid && wr));
        check({tag, " fx_rd count"}, 32'(nrd), 32'(valid && !wr));
        check({tag, " rd&wr overlap"}, 32'(both), 32'd0);
        if (valid) check({tag, " strobe cycle"}, 32'(wr ? wr_at : rd_at), 32'd2);
        check({tag, " fx_a at setup"}, 32'(a1), 32'(valid ? addr[7:0] : 8'h00));
        check({tag, " fx_d at setup"}, 32'(d1), 32'(valid ? wd : 8'h00));
        step;
        check({tag, " idle after ack"}, {27'd0, host_ack, busy, fx_rd, fx_wr, |fx_cs}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  cs;
        int          lat;
        logic        err;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [7:0] m_cs, m_rdata, cs_log [21], rd2;
        int m_lat, cyc, nack, ack1, ack2, seen;
        logic m_err, w;
        logic [15:0] a;
        logic [7:0] a1;
        int nrd1, nwr1;

        vecs[0]  = '{1'b1, 16'h0410, 8'hC3, 8'h10, 3, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 16'h0205, 8'h5A, 8'h04, 3, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 16'h0205, 8'h00, 8'h04, 5, 1'b0, 8'h5A};
        vecs[3]  = '{1'b0, 16'h0410, 8'h00, 8'h10, 5, 1'b0, 8'hC3};
        vecs[4]  = '{1'b0, 16'h0900, 8'h00, 8'h00, 1, 1'b1, 8'hEE};
        vecs[5]  = '{1'b1, 16'h0000, 8'h11, 8'h01, 3, 1'b0, 8'hEE};
        vecs[6]  = '{1'b0, 16'h0000, 8'h00, 8'h01, 5, 1'b0, 8'h11};
        vecs[7]  = '{1'b1, 16'hFF12, 8'h77, 8'h00, 1, 1'b1, 8'hEE};
        vecs[8]  = '{1'b1, 16'h07FE, 8'hA5, 8'h80, 3, 1'b0, 8'hEE};
        vecs[9]  = '{1'b0, 16'h07FE, 8'h00, 8'h80, 5, 1'b0, 8'hA5};
        vecs[10] = '{1'b0, 16'h0103, 8'h00, 8'h02, 5, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 16'h0800, 8'h00, 8'h00, 1, 1'b1, 8'hEE};

        for (int s = 0; s < 8; s++)
            for (int r = 0; r < 256; r++) ref_mem[s][r] = 8'h00;
        last_rdata = 8'h00;

        rst_n = 1'b0; mem_clr = 1'b1;
        host_req = 1'b0; host_wr = 1'b0; host_addr = 16'h0; host_wdata = 8'h0;
        l1_req = 1'b0; l1_wr = 1'b0; l1_addr = 16'h0; l1_wdata = 8'h0;
        step;
        step;
        check("reset outputs", {host_ack, host_err, busy, fx_wr, fx_rd, host_rdata, fx_cs, fx_a},
              32'd0);
        check("reset fx_d", 32'(fx_d), 32'd0);
        rst_n = 1'b1; mem_clr = 1'b0;
        step;

        for (int i = 0; i < 12; i++) begin
            model(vecs[i].wr, vecs[i].addr, vecs[i].wd, m_cs, m_lat, m_err, m_rdata);
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd,
                    vecs[i].cs, vecs[i].lat, vecs[i].err, vecs[i].rdata);
        end

        // Reset asserted during the read-latency wait
        host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0410;
        step;
        host_req = 1'b0;
        step;
        step;
        check("mid-read busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-read reset outputs",
              {host_ack, host_err, busy, fx_wr, fx_rd, host_rdata, fx_cs, fx_a}, 32'd0);
        step;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            step;
            if (host_ack || busy) seen++;
        end
        check("no ack after reset abort", 32'(seen), 32'd0);
        last_rdata = 8'h00;
        model(1'b0, 16'h0410, 8'h00, m_cs, m_lat, m_err, m_rdata);
        run_txn("post-reset read", 1'b0, 16'h0410, 8'h00, m_cs, m_lat, m_err, m_rdata);

        // Back-to-back with host_req held high across the first ack
        for (int i = 0; i < 21; i++) cs_log[i] = 8'hFF;
        host_req = 1'b1; host_wr = 1'b1; host_addr = 16'h0001; host_wdata = 8'h33;
        cyc = 0; nack = 0; ack1 = 0; ack2 = 0; rd2 = 8'hFF;
        while (cyc < 20) begin
            step;
            cyc++;
            cs_log[cyc] = fx_cs;
            if (host_ack) begin
                nack++;
                if (nack == 1) begin
                    ack1 = cyc; host_wr = 1'b0; host_addr = 16'h0702;
                end else begin
                    ack2 = cyc; rd2 = host_rdata; host_req = 1'b0;
                    break;
                end
            end
        end
        host_req = 1'b0;
        step;
        check("b2b first ack cycle", 32'(ack1), 32'd3);
        check("b2b second ack cycle", 32'(ack2), 32'd9);
        check("b2b fx_cs c1", 32'(cs_log[1]), 32'h01);
        check("b2b fx_cs c3", 32'(cs_log[3]), 32'h00);
        check("b2b fx_cs c4", 32'(cs_log[4]), 32'h00);
        check("b2b fx_cs c5", 32'(cs_log[5]), 32'h80);
        check("b2b read data", 32'(rd2), 32'h00);
        model(1'b1, 16'h0001, 8'h33, m_cs, m_lat, m_err, m_rdata);
        model(1'b0, 16'h0702, 8'h00, m_cs, m_lat, m_err, m_rdata);

        // Random accesses against the register-file model
        for (int i = 0; i < 40; i++) begin
            int base;
            w = 1'($urandom_range(0, 1));
            base = int'($urandom_range(0, 9));
            if (base == 9) base = int'($urandom_range(8, 255));
            a = {8'(base), 8'($urandom_range(0, 3))};
            a1 = 8'($urandom);
            model(w, a, a1, m_cs, m_lat, m_err, m_rdata);
            run_txn($sformatf("rnd%0d", i), w, a, a1, m_cs, m_lat, m_err, m_rdata);
        end

        // Single-cycle read latency instance
        l1_req = 1'b1; l1_wr = 1'b0; l1_addr = 16'h0300; l1_wdata = 8'h9C;
        step;
        cyc = 1;
        check("lat1 fx_cs at setup", 32'(l1_fx_cs), 32'h08);
        check("lat1 fx_a/fx_d at setup", {16'd0, l1_fx_a, l1_fx_d}, 32'h009C);
        l1_req = 1'b0;
        nrd1 = 0; nwr1 = 0;
        while (1) begin
            if (l1_fx_rd) nrd1++;
            if (l1_fx_wr) nwr1++;
            if (l1_ack || cyc >= 20) break;
            step;
            cyc++;
        end
        check("lat1 ack latency", 32'(cyc), 32'd4);
        check("lat1 host_rdata", 32'(l1_rdata), 32'h7E);
        check("lat1 host_err", 32'(l1_err), 32'd0);
        check("lat1 strobes rd/wr", {nrd1[15:0], nwr1[15:0]}, 32'h0001_0000);
        step;
        check("lat1 idle after ack", {30'd0, l1_ack, l1_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
